// File: rtl/ctrl_pkg.sv
// Shared control definitions for the pipelined MIPS controller: opcodes, functs,
// ALU codes and the per-stage control word carried down the E/M/W registers.
package ctrl_pkg;

  localparam int ALU_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    MF_NONE = 2'b00,
    MF_HI   = 2'b01,
    MF_LO   = 2'b10
  } mfhl_e;

  // Fields grouped by the last stage that consumes them, so each register
  // only carries what is still needed downstream.
  typedef struct packed {
    logic             alusrc;
    regdst_e          regdst;
    logic [ALU_W-1:0] alucontrol;
    logic             multordiv;
    logic             div;
  } ctrl_e_t;

  typedef struct packed {
    logic memwrite;
    logic sb;
  } ctrl_m_t;

  typedef struct packed {
    logic  regwrite;
    logic  memtoreg;
    logic  jal;
    logic  lb;
    mfhl_e mfhl;
  } ctrl_w_t;

  typedef struct packed {
    ctrl_e_t e;
    ctrl_m_t m;
    ctrl_w_t w;
  } ctrl_t;

  typedef struct packed {
    ctrl_m_t m;
    ctrl_w_t w;
  } ctrl_mw_t;

endpackage

// File: rtl/mdu_seq.sv
// Mult/div occupancy sequencer: loads MDU_LAT on start, counts down, and pulses
// hl_we on the last busy cycle so HI/LO are written exactly once per operation.
module mdu_seq #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic mdu_busy_o,
  output logic hl_we_o
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = CNT_W'(MDU_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign mdu_busy_o = (cnt_q != '0);
  assign hl_we_o    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_controller_mdu.sv
// Pipelined MIPS controller: combinational Decode, D->E register with
// flush/stall, free-running E->M->W registers, and the mult/div sequencer.
module pipe_controller_mdu
  import ctrl_pkg::*;
#(
  parameter int MDU_LAT   = 4,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opD,
  input  logic [5:0]           functD,
  input  logic                 equalD,
  input  logic                 stallE,
  input  logic                 flushE,
  output logic                 pcsrcD,
  output logic                 branchD,
  output logic                 bneD,
  output logic                 jumpD,
  output logic                 jalD,
  output logic                 jrD,
  output logic                 mdstallD,
  output logic                 memtoregE,
  output logic                 memtoregM,
  output logic                 memtoregW,
  output logic                 regwriteE,
  output logic                 regwriteM,
  output logic                 regwriteW,
  output logic                 alusrcE,
  output logic [1:0]           regdstE,
  output logic [ALUCTRL_W-1:0] alucontrolE,
  output logic                 multordivE,
  output logic                 divE,
  output logic                 memwriteM,
  output logic                 sbM,
  output logic                 jalW,
  output logic                 lbW,
  output logic [1:0]           mfhlW,
  output logic                 mdu_busy,
  output logic                 hl_we
);

  ctrl_t    e_d, e_q;
  ctrl_mw_t m_q;
  ctrl_w_t  w_q;
  logic     md_opD;
  logic     mdu_start;

  always_comb begin
    e_d     = '0;
    branchD = 1'b0;
    bneD    = 1'b0;
    jumpD   = 1'b0;
    jalD    = 1'b0;
    jrD     = 1'b0;
    md_opD  = 1'b0;
    case (opD)
      OP_RTYPE: begin
        case (functD)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            e_d.w.regwrite = 1'b1;
            e_d.e.regdst   = RD_RD;
            case (functD)
              F_ADD:   e_d.e.alucontrol = ALU_ADD;
              F_SUB:   e_d.e.alucontrol = ALU_SUB;
              F_AND:   e_d.e.alucontrol = ALU_AND;
              F_OR:    e_d.e.alucontrol = ALU_OR;
              default: e_d.e.alucontrol = ALU_SLT;
            endcase
          end
          F_JR: jrD = 1'b1;
          F_MULT, F_DIV: begin
            md_opD          = 1'b1;
            e_d.e.multordiv = 1'b1;
            e_d.e.div       = (functD == F_DIV);
          end
          F_MFHI, F_MFLO: begin
            md_opD         = 1'b1;
            e_d.w.regwrite = 1'b1;
            e_d.e.regdst   = RD_RD;
            e_d.w.mfhl     = (functD == F_MFHI) ? MF_HI : MF_LO;
          end
          default: ;
        endcase
      end
      OP_LW, OP_LB: begin
        e_d.w.regwrite   = 1'b1;
        e_d.w.memtoreg   = 1'b1;
        e_d.e.alusrc     = 1'b1;
        e_d.e.alucontrol = ALU_ADD;
        e_d.w.lb         = (opD == OP_LB);
      end
      OP_SW, OP_SB: begin
        e_d.m.memwrite   = 1'b1;
        e_d.e.alusrc     = 1'b1;
        e_d.e.alucontrol = ALU_ADD;
        e_d.m.sb         = (opD == OP_SB);
      end
      OP_ADDI: begin
        e_d.w.regwrite   = 1'b1;
        e_d.e.alusrc     = 1'b1;
        e_d.e.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        branchD          = 1'b1;
        e_d.e.alucontrol = ALU_SUB;
      end
      OP_BNE: begin
        bneD             = 1'b1;
        e_d.e.alucontrol = ALU_SUB;
      end
      OP_J: jumpD = 1'b1;
      OP_JAL: begin
        jumpD          = 1'b1;
        jalD           = 1'b1;
        e_d.w.jal      = 1'b1;
        e_d.w.regwrite = 1'b1;
        e_d.e.regdst   = RD_RA;
      end
      default: ;
    endcase
  end

  assign pcsrcD = (branchD & equalD) | (bneD & ~equalD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (flushE)       e_q <= '0;
      else if (!stallE) e_q <= e_d;
      m_q <= '{m: e_q.m, w: e_q.w};
      w_q <= m_q.w;
    end
  end

  // A flushed mult still starts: the instruction is leaving E either way.
  assign mdu_start = e_q.e.multordiv & ~stallE;

  mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mdu_start),
    .mdu_busy_o(mdu_busy),
    .hl_we_o   (hl_we)
  );

  assign mdstallD    = mdu_busy & md_opD;

  assign memtoregE   = e_q.w.memtoreg;
  assign regwriteE   = e_q.w.regwrite;
  assign alusrcE     = e_q.e.alusrc;
  assign regdstE     = e_q.e.regdst;
  assign alucontrolE = ALUCTRL_W'(e_q.e.alucontrol);
  assign multordivE  = e_q.e.multordiv;
  assign divE        = e_q.e.div;

  assign memtoregM   = m_q.w.memtoreg;
  assign regwriteM   = m_q.w.regwrite;
  assign memwriteM   = m_q.m.memwrite;
  assign sbM         = m_q.m.sb;

  assign memtoregW   = w_q.memtoreg;
  assign regwriteW   = w_q.regwrite;
  assign jalW        = w_q.jal;
  assign lbW         = w_q.lb;
  assign mfhlW       = w_q.mfhl;

endmodule

// File: tb/tb_pipe_controller_mdu.sv
// Scoreboard bench: directed and random instruction streams, expected outputs
// from an instruction-table model pushed to a queue and checked by a monitor.
module tb_pipe_controller_mdu;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opD = '0, functD = '0;
  logic equalD = 1'b0, stallE = 1'b0, flushE = 1'b0;

  logic pcsrcD, branchD, bneD, jumpD, jalD, jrD, mdstallD;
  logic memtoregE, memtoregM, memtoregW, regwriteE, regwriteM, regwriteW;
  logic alusrcE, multordivE, divE, memwriteM, sbM, jalW, lbW, mdu_busy, hl_we;
  logic [1:0] regdstE, mfhlW;
  logic [3:0] alucontrolE;

  // second instance at the MDU_LAT=1 boundary; only MDU outputs are checked
  logic u1_pcsrc, u1_br, u1_bne, u1_j, u1_jal, u1_jr, u1_mdstall;
  logic u1_mtrE, u1_mtrM, u1_mtrW, u1_rwE, u1_rwM, u1_rwW;
  logic u1_asE, u1_mdE, u1_divE, u1_mwM, u1_sbM, u1_jalW, u1_lbW, u1_busy, u1_hlwe;
  logic [1:0] u1_rdE, u1_mfW;
  logic [3:0] u1_aluE;

  always #5 clk = ~clk;

  pipe_controller_mdu #(.MDU_LAT(LAT), .ALUCTRL_W(4)) dut (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD),
    .stallE(stallE), .flushE(flushE), .pcsrcD(pcsrcD), .branchD(branchD),
    .bneD(bneD), .jumpD(jumpD), .jalD(jalD), .jrD(jrD), .mdstallD(mdstallD),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .alusrcE(alusrcE), .regdstE(regdstE), .alucontrolE(alucontrolE),
    .multordivE(multordivE), .divE(divE), .memwriteM(memwriteM), .sbM(sbM),
    .jalW(jalW), .lbW(lbW), .mfhlW(mfhlW), .mdu_busy(mdu_busy), .hl_we(hl_we)
  );

  pipe_controller_mdu #(.MDU_LAT(1), .ALUCTRL_W(4)) dut1 (
    .clk(clk), .reset(reset), .opD(opD), .functD(functD), .equalD(equalD),
    .stallE(stallE), .flushE(flushE), .pcsrcD(u1_pcsrc), .branchD(u1_br),
    .bneD(u1_bne), .jumpD(u1_j), .jalD(u1_jal), .jrD(u1_jr), .mdstallD(u1_mdstall),
    .memtoregE(u1_mtrE), .memtoregM(u1_mtrM), .memtoregW(u1_mtrW),
    .regwriteE(u1_rwE), .regwriteM(u1_rwM), .regwriteW(u1_rwW),
    .alusrcE(u1_asE), .regdstE(u1_rdE), .alucontrolE(u1_aluE),
    .multordivE(u1_mdE), .divE(u1_divE), .memwriteM(u1_mwM), .sbM(u1_sbM),
    .jalW(u1_jalW), .lbW(u1_lbW), .mfhlW(u1_mfW), .mdu_busy(u1_busy), .hl_we(u1_hlwe)
  );

  typedef struct packed {
    logic regwrite, memtoreg, memwrite, sb, lb, alusrc;
    logic [1:0] regdst;
    logic [3:0] alu;
    logic md, div, jal;
    logic [1:0] mfhl;
    logic branch, bne, jump, jr, mdop;
  } cw_t;

  typedef struct packed {
    cw_t d, e, m, w;
    logic pcsrc, mdstall, busy, hlwe, mdstall1, busy1, hlwe1;
  } exp_t;

  // Instruction table written straight from the ISA description.
  function automatic cw_t dec(input logic [5:0] op, input logic [5:0] fn);
    cw_t c = '0;
    case (op)
      6'o00: case (fn)
        6'h20: begin c.regwrite = 1; c.regdst = 2'b01; c.alu = 4'b0010; end
        6'h22: begin c.regwrite = 1; c.regdst = 2'b01; c.alu = 4'b0110; end
        6'h24: begin c.regwrite = 1; c.regdst = 2'b01; c.alu = 4'b0000; end
        6'h25: begin c.regwrite = 1; c.regdst = 2'b01; c.alu = 4'b0001; end
        6'h2a: begin c.regwrite = 1; c.regdst = 2'b01; c.alu = 4'b0111; end
        6'h08: c.jr = 1;
        6'h18: begin c.md = 1; c.mdop = 1; end
        6'h1a: begin c.md = 1; c.div = 1; c.mdop = 1; end
        6'h10: begin c.regwrite = 1; c.regdst = 2'b01; c.mfhl = 2'b01; c.mdop = 1; end
        6'h12: begin c.regwrite = 1; c.regdst = 2'b01; c.mfhl = 2'b10; c.mdop = 1; end
        default: ;
      endcase
      6'h23: begin c.regwrite = 1; c.memtoreg = 1; c.alusrc = 1; c.alu = 4'b0010; end
      6'h20: begin c.regwrite = 1; c.memtoreg = 1; c.alusrc = 1; c.alu = 4'b0010; c.lb = 1; end
      6'h2b: begin c.memwrite = 1; c.alusrc = 1; c.alu = 4'b0010; end
      6'h28: begin c.memwrite = 1; c.alusrc = 1; c.alu = 4'b0010; c.sb = 1; end
      6'h08: begin c.regwrite = 1; c.alusrc = 1; c.alu = 4'b0010; end
      6'h04: begin c.branch = 1; c.alu = 4'b0110; end
      6'h05: begin c.bne = 1; c.alu = 4'b0110; end
      6'h02: c.jump = 1;
      6'h03: begin c.jump = 1; c.regwrite = 1; c.regdst = 2'b10; c.jal = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Model state: stage contents plus the edge number of the last MDU start.
  cw_t mE = '0, mM = '0, mW = '0;
  int  edge_n = 0;
  int  last_start = -1000;
  logic [5:0] p_op = '0, p_fn = '0;
  logic p_st = 0, p_fl = 0, p_rs = 1;

  exp_t q[$];
  int nvec = 0, nbad = 0;

  function automatic logic busy_for(input int L);
    return (edge_n - last_start) < L;
  endfunction

  function automatic logic hlwe_for(input int L);
    return (edge_n - last_start) == L - 1;
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic eq, input logic st, input logic fl, input logic rs);
    exp_t x;
    cw_t  d;
    @(negedge clk);
    edge_n++;
    if (p_rs) begin
      mE = '0; mM = '0; mW = '0; last_start = -1000;
    end else begin
      if (mE.md && !p_st) last_start = edge_n;
      mW = mM;
      mM = mE;
      if (p_fl)       mE = '0;
      else if (!p_st) mE = dec(p_op, p_fn);
    end
    // act as the hazard unit: a mult/div may not leave E while the MDU is busy
    if (mE.md && busy_for(LAT)) st = 1'b1;
    opD = op; functD = fn; equalD = eq; stallE = st; flushE = fl; reset = rs;
    p_op = op; p_fn = fn; p_st = st; p_fl = fl; p_rs = rs;
    if (rs) begin
      mE = '0; mM = '0; mW = '0; last_start = -1000;
    end
    d = dec(op, fn);
    x.d = d; x.e = mE; x.m = mM; x.w = mW;
    x.pcsrc    = (d.branch & eq) | (d.bne & ~eq);
    x.busy     = busy_for(LAT);
    x.hlwe     = hlwe_for(LAT);
    x.mdstall  = x.busy & d.mdop;
    x.busy1    = busy_for(1);
    x.hlwe1    = hlwe_for(1);
    x.mdstall1 = x.busy1 & d.mdop;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at vector %0d: got %0h expected %0h", nm, nvec, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        nvec++;
        chk("pcsrcD", 8'(pcsrcD), 8'(x.pcsrc));
        chk("branchD", 8'(branchD), 8'(x.d.branch));
        chk("bneD", 8'(bneD), 8'(x.d.bne));
        chk("jumpD", 8'(jumpD), 8'(x.d.jump));
        chk("jalD", 8'(jalD), 8'(x.d.jal));
        chk("jrD", 8'(jrD), 8'(x.d.jr));
        chk("mdstallD", 8'(mdstallD), 8'(x.mdstall));
        chk("regwriteE", 8'(regwriteE), 8'(x.e.regwrite));
        chk("memtoregE", 8'(memtoregE), 8'(x.e.memtoreg));
        chk("alusrcE", 8'(alusrcE), 8'(x.e.alusrc));
        chk("regdstE", 8'(regdstE), 8'(x.e.regdst));
        chk("alucontrolE", 8'(alucontrolE), 8'(x.e.alu));
        chk("multordivE", 8'(multordivE), 8'(x.e.md));
        chk("divE", 8'(divE), 8'(x.e.div));
        chk("regwriteM", 8'(regwriteM), 8'(x.m.regwrite));
        chk("memtoregM", 8'(memtoregM), 8'(x.m.memtoreg));
        chk("memwriteM", 8'(memwriteM), 8'(x.m.memwrite));
        chk("sbM", 8'(sbM), 8'(x.m.sb));
        chk("regwriteW", 8'(regwriteW), 8'(x.w.regwrite));
        chk("memtoregW", 8'(memtoregW), 8'(x.w.memtoreg));
        chk("jalW", 8'(jalW), 8'(x.w.jal));
        chk("lbW", 8'(lbW), 8'(x.w.lb));
        chk("mfhlW", 8'(mfhlW), 8'(x.w.mfhl));
        chk("mdu_busy", 8'(mdu_busy), 8'(x.busy));
        chk("hl_we", 8'(hl_we), 8'(x.hlwe));
        chk("lat1_busy", 8'(u1_busy), 8'(x.busy1));
        chk("lat1_hl_we", 8'(u1_hlwe), 8'(x.hlwe1));
        chk("lat1_mdstallD", 8'(u1_mdstall), 8'(x.mdstall1));
        chk("start_while_busy", 8'(multordivE & ~stallE & mdu_busy & ~reset), 8'h0);
      end
    end
  end

  // random pool of legal ops plus two undefined encodings
  logic [11:0] pool [21] = '{
    {6'o00, 6'h20}, {6'o00, 6'h22}, {6'o00, 6'h24}, {6'o00, 6'h25}, {6'o00, 6'h2a},
    {6'o00, 6'h08}, {6'o00, 6'h18}, {6'o00, 6'h1a}, {6'o00, 6'h10}, {6'o00, 6'h12},
    {6'h23, 6'h00}, {6'h20, 6'h00}, {6'h2b, 6'h00}, {6'h28, 6'h00}, {6'h08, 6'h00},
    {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00},
    {6'o00, 6'h3f}
  };

  initial begin : stim
    logic [11:0] pe;
    logic [5:0]  fn;
    step(6'h00, 6'h00, 0, 0, 0, 1);
    step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h00, 6'h08, 0, 0, 0, 0);                     // jr
    repeat (3) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h23, 6'h00, 0, 0, 0, 0);                     // lw
    repeat (3) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h04, 6'h00, 1, 0, 0, 0);                     // beq taken
    step(6'h05, 6'h00, 1, 0, 0, 0);                     // bne not taken
    step(6'h05, 6'h00, 0, 0, 0, 0);                     // bne taken
    step(6'h00, 6'h18, 0, 0, 0, 0);                     // mult
    repeat (6) step(6'h00, 6'h12, 0, 0, 0, 0);          // mflo stalls while busy
    repeat (3) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h2b, 6'h00, 0, 0, 0, 0);                     // sw, flushed next
    step(6'h00, 6'h00, 0, 0, 1, 0);
    repeat (2) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h00, 6'h2a, 0, 0, 0, 0);                     // slt, then hold in E
    step(6'h23, 6'h00, 0, 1, 0, 0);
    step(6'h23, 6'h00, 0, 1, 0, 0);
    step(6'h23, 6'h00, 0, 1, 1, 0);                     // flush wins over stall
    step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h00, 6'h18, 0, 0, 0, 0);                     // mult flushed as it starts
    step(6'h00, 6'h00, 0, 0, 1, 0);
    repeat (5) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h00, 6'h1a, 0, 0, 0, 0);                     // div, reset mid-count
    repeat (3) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h00, 6'h00, 0, 0, 0, 1);
    repeat (5) step(6'h00, 6'h00, 0, 0, 0, 0);
    step(6'h3f, 6'h3f, 1, 0, 0, 0);                     // undefined opcode
    repeat (3) step(6'h00, 6'h00, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      pe = pool[$urandom_range(0, 20)];
      fn = (pe[11:6] == 6'o00) ? pe[5:0] : 6'($urandom);
      step(pe[11:6], fn, 1'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 59) == 0));
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
